// File: rtl/mvu_job_dispatcher.sv
// MVU job dispatcher: per-hart job snapshots, round-robin
// arbitration and launch/irq sequencing for one shared MVU engine.
module mvu_job_dispatcher #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = 3,
  parameter int CD_W           = 29
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_HARTS-1:0]          mvu_start,
  input  logic [CD_W*NUM_HARTS-1:0]     csr_mvu_countdown,
  input  logic [6*NUM_HARTS-1:0]        csr_mvu_wprecision,
  input  logic [6*NUM_HARTS-1:0]        csr_mvu_iprecision,
  input  logic [6*NUM_HARTS-1:0]        csr_mvu_oprecision,
  input  logic [15*NUM_HARTS-1:0]       csr_mvu_ibaseaddr,
  input  logic [15*NUM_HARTS-1:0]       csr_mvu_obaseaddr,
  output logic [NUM_HARTS-1:0]          mvu_irq,
  output logic [NUM_HARTS-1:0]          pending,
  output logic [NUM_HARTS-1:0]          drop_err,
  output logic                          eng_start,
  output logic                          eng_busy,
  output logic [HART_CNT_WIDTH-1:0]     eng_hart,
  output logic [CD_W-1:0]               eng_countdown,
  output logic [5:0]                    eng_wprec,
  output logic [5:0]                    eng_iprec,
  output logic [5:0]                    eng_oprec,
  output logic [14:0]                   eng_ibase,
  output logic [14:0]                   eng_obase
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_e;

  state_e                      state_q;
  logic [CD_W-1:0]             cnt_q;
  logic [HART_CNT_WIDTH-1:0]   last_q;

  logic [NUM_HARTS-1:0]        start_q;
  logic [NUM_HARTS-1:0]        pend_q;
  logic [NUM_HARTS-1:0]        pend_d;
  logic [NUM_HARTS-1:0]        drop_q;
  logic [NUM_HARTS-1:0]        drop_d;
  logic [NUM_HARTS-1:0]        irq_q;

  logic                        eng_start_q;
  logic                        eng_busy_q;
  logic [HART_CNT_WIDTH-1:0]   eng_hart_q;
  logic [CD_W-1:0]             eng_cd_q;
  logic [5:0]                  eng_wp_q;
  logic [5:0]                  eng_ip_q;
  logic [5:0]                  eng_op_q;
  logic [14:0]                 eng_ib_q;
  logic [14:0]                 eng_ob_q;

  logic [CD_W-1:0]             snap_cd_q [NUM_HARTS];
  logic [5:0]                  snap_wp_q [NUM_HARTS];
  logic [5:0]                  snap_ip_q [NUM_HARTS];
  logic [5:0]                  snap_op_q [NUM_HARTS];
  logic [14:0]                 snap_ib_q [NUM_HARTS];
  logic [14:0]                 snap_ob_q [NUM_HARTS];

  logic [NUM_HARTS-1:0]        new_req;
  logic [NUM_HARTS-1:0]        active;
  logic [NUM_HARTS-1:0]        accept;
  logic [NUM_HARTS-1:0]        gnt_mask;
  logic                        gnt_vld;
  logic [HART_CNT_WIDTH-1:0]   gnt_idx;
  logic [HART_CNT_WIDTH-1:0]   rr_idx;

  // Round-robin pick: first pending hart after the last one served.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    for (int i = 1; i <= NUM_HARTS; i++) begin
      rr_idx = HART_CNT_WIDTH'((int'(last_q) + i) % NUM_HARTS);
      if (!gnt_vld && pend_q[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  // Start edges, ownership, accept/drop and next pending set.
  always_comb begin
    new_req  = mvu_start & ~start_q;
    active   = '0;
    gnt_mask = '0;
    if (state_q == S_LAUNCH || state_q == S_RUN) begin
      active[eng_hart_q] = 1'b1;
    end
    if (state_q == S_IDLE && gnt_vld) begin
      gnt_mask[gnt_idx] = 1'b1;
    end
    accept = new_req & ~pend_q & ~active;
    drop_d = new_req & (pend_q | active);
    pend_d = (pend_q & ~gnt_mask) | accept;
  end

  // Request side: edge history, pending slots, snapshots, drop pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        snap_cd_q[h] <= '0;
        snap_wp_q[h] <= '0;
        snap_ip_q[h] <= '0;
        snap_op_q[h] <= '0;
        snap_ib_q[h] <= '0;
        snap_ob_q[h] <= '0;
      end
    end else begin
      start_q <= mvu_start;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (accept[h]) begin
          snap_cd_q[h] <= csr_mvu_countdown[h*CD_W +: CD_W];
          snap_wp_q[h] <= csr_mvu_wprecision[h*6 +: 6];
          snap_ip_q[h] <= csr_mvu_iprecision[h*6 +: 6];
          snap_op_q[h] <= csr_mvu_oprecision[h*6 +: 6];
          snap_ib_q[h] <= csr_mvu_ibaseaddr[h*15 +: 15];
          snap_ob_q[h] <= csr_mvu_obaseaddr[h*15 +: 15];
        end
      end
    end
  end

  // Engine FSM: grant, launch strobe, countdown and done irq.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= HART_CNT_WIDTH'(NUM_HARTS - 1);
      irq_q       <= '0;
      eng_start_q <= 1'b0;
      eng_busy_q  <= 1'b0;
      eng_hart_q  <= '0;
      eng_cd_q    <= '0;
      eng_wp_q    <= '0;
      eng_ip_q    <= '0;
      eng_op_q    <= '0;
      eng_ib_q    <= '0;
      eng_ob_q    <= '0;
    end else begin
      eng_start_q <= 1'b0;
      irq_q       <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            state_q     <= S_LAUNCH;
            eng_start_q <= 1'b1;
            eng_busy_q  <= 1'b1;
            eng_hart_q  <= gnt_idx;
            cnt_q       <= snap_cd_q[gnt_idx];
            eng_cd_q    <= snap_cd_q[gnt_idx];
            eng_wp_q    <= snap_wp_q[gnt_idx];
            eng_ip_q    <= snap_ip_q[gnt_idx];
            eng_op_q    <= snap_op_q[gnt_idx];
            eng_ib_q    <= snap_ib_q[gnt_idx];
            eng_ob_q    <= snap_ob_q[gnt_idx];
          end
        end
        S_LAUNCH: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            irq_q   <= NUM_HARTS'(1) << eng_hart_q;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_q == CD_W'(1)) begin
            state_q <= S_DONE;
            irq_q   <= NUM_HARTS'(1) << eng_hart_q;
          end else begin
            cnt_q <= cnt_q - CD_W'(1);
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          eng_busy_q <= 1'b0;
          last_q     <= eng_hart_q;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mvu_irq       = irq_q;
  assign pending       = pend_q;
  assign drop_err      = drop_q;
  assign eng_start     = eng_start_q;
  assign eng_busy      = eng_busy_q;
  assign eng_hart      = eng_hart_q;
  assign eng_countdown = eng_cd_q;
  assign eng_wprec     = eng_wp_q;
  assign eng_iprec     = eng_ip_q;
  assign eng_oprec     = eng_op_q;
  assign eng_ibase     = eng_ib_q;
  assign eng_obase     = eng_ob_q;

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// Directed bench for mvu_job_dispatcher: latency, arbitration,
// drop handling and reset abort with hand-computed expectations.
module tb_mvu_job_dispatcher;

  localparam int NH = 8;
  localparam int HW = 3;
  localparam int CW = 29;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NH-1:0]   mvu_start = '0;
  logic [CW*NH-1:0] cd_v = '0;
  logic [6*NH-1:0] wp_v = '0;
  logic [6*NH-1:0] ip_v = '0;
  logic [6*NH-1:0] op_v = '0;
  logic [15*NH-1:0] ib_v = '0;
  logic [15*NH-1:0] ob_v = '0;

  logic [NH-1:0]   mvu_irq;
  logic [NH-1:0]   pending;
  logic [NH-1:0]   drop_err;
  logic            eng_start;
  logic            eng_busy;
  logic [HW-1:0]   eng_hart;
  logic [CW-1:0]   eng_countdown;
  logic [5:0]      eng_wprec;
  logic [5:0]      eng_iprec;
  logic [5:0]      eng_oprec;
  logic [14:0]     eng_ibase;
  logic [14:0]     eng_obase;

  int total  = 0;
  int passed = 0;

  mvu_job_dispatcher #(
    .NUM_HARTS(NH),
    .HART_CNT_WIDTH(HW),
    .CD_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mvu_start(mvu_start),
    .csr_mvu_countdown(cd_v),
    .csr_mvu_wprecision(wp_v),
    .csr_mvu_iprecision(ip_v),
    .csr_mvu_oprecision(op_v),
    .csr_mvu_ibaseaddr(ib_v),
    .csr_mvu_obaseaddr(ob_v),
    .mvu_irq(mvu_irq),
    .pending(pending),
    .drop_err(drop_err),
    .eng_start(eng_start),
    .eng_busy(eng_busy),
    .eng_hart(eng_hart),
    .eng_countdown(eng_countdown),
    .eng_wprec(eng_wprec),
    .eng_iprec(eng_iprec),
    .eng_oprec(eng_oprec),
    .eng_ibase(eng_ibase),
    .eng_obase(eng_obase)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg(int h, logic [28:0] cd, logic [5:0] w,
                     logic [5:0] i, logic [5:0] o,
                     logic [14:0] ib, logic [14:0] ob);
    cd_v[h*CW +: CW] = cd;
    wp_v[h*6 +: 6]   = w;
    ip_v[h*6 +: 6]   = i;
    op_v[h*6 +: 6]   = o;
    ib_v[h*15 +: 15] = ib;
    ob_v[h*15 +: 15] = ob;
  endtask

  task automatic check_zero(string tag);
    check({tag, " ctl"},
          32'({pending, drop_err, mvu_irq, eng_start, eng_busy, eng_hart}),
          32'd0);
    check({tag, " cd"}, 32'(eng_countdown), 32'd0);
    check({tag, " prec"}, 32'({eng_wprec, eng_iprec, eng_oprec}), 32'd0);
    check({tag, " base"}, 32'({eng_ibase, eng_obase}), 32'd0);
  endtask

  task automatic wait_start(string tag, output int n);
    n = 0;
    while (eng_start !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check({tag, " start seen"}, 32'(eng_start), 32'd1);
  endtask

  task automatic wait_irq(string tag, input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (mvu_irq == '0 && n < lim);
    check({tag, " irq seen"}, 32'(mvu_irq != '0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int order[3] = '{1, 4, 6};
    bit seen;

    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // single job on hart 2, countdown 5
    cfg(2, 29'd5, 6'd3, 6'd4, 6'd5, 15'h123, 15'h456);
    mvu_start[2] = 1'b1;
    step();
    check("t1 pending", 32'(pending), 32'h04);
    check("t1 no start", 32'(eng_start), 32'd0);
    mvu_start[2] = 1'b0;
    step();
    check("t1 start", 32'(eng_start), 32'd1);
    check("t1 hart", 32'(eng_hart), 32'd2);
    check("t1 cd", 32'(eng_countdown), 32'd5);
    check("t1 prec", 32'({eng_wprec, eng_iprec, eng_oprec}),
          32'({6'd3, 6'd4, 6'd5}));
    check("t1 base", 32'({eng_ibase, eng_obase}),
          32'({15'h123, 15'h456}));
    check("t1 pend clr", 32'(pending), 32'd0);
    check("t1 busy", 32'(eng_busy), 32'd1);
    for (int k = 3; k <= 7; k++) begin
      step();
      check("t1 irq early", 32'(mvu_irq), 32'd0);
    end
    step();
    check("t1 irq", 32'(mvu_irq), 32'h04);
    step();
    check("t1 idle", 32'(eng_busy), 32'd0);
    check("t1 irq off", 32'(mvu_irq), 32'd0);
    check("t1 hart kept", 32'(eng_hart), 32'd2);
    check("t1 cd kept", 32'(eng_countdown), 32'd5);

    // countdown 0 on hart 0, start held high
    cfg(0, 29'd0, 6'd1, 6'd1, 6'd1, 15'h001, 15'h002);
    mvu_start[0] = 1'b1;
    step();
    check("t2 pending", 32'(pending), 32'h01);
    step();
    check("t2 start", 32'(eng_start), 32'd1);
    check("t2 hart", 32'(eng_hart), 32'd0);
    check("t2 cd", 32'(eng_countdown), 32'd0);
    step();
    check("t2 irq", 32'(mvu_irq), 32'h01);
    check("t2 start off", 32'(eng_start), 32'd0);
    step();
    check("t2 idle", 32'(eng_busy), 32'd0);
    step();
    step();
    check("t2 held no req", 32'({pending, drop_err}), 32'd0);
    mvu_start[0] = 1'b0;
    step();

    // simultaneous starts from harts 1, 4, 6
    cfg(1, 29'd2, 6'd1, 6'd0, 6'd0, 15'h011, 15'h0);
    cfg(4, 29'd2, 6'd4, 6'd0, 6'd0, 15'h044, 15'h0);
    cfg(6, 29'd2, 6'd6, 6'd0, 6'd0, 15'h066, 15'h0);
    mvu_start = 8'b0101_0010;
    step();
    check("t3 pending", 32'(pending), 32'h52);
    mvu_start = '0;
    for (int j = 0; j < 3; j++) begin
      wait_start("t3", n);
      check("t3 order", 32'(eng_hart), 32'(order[j]));
      check("t3 wprec", 32'(eng_wprec), 32'(order[j]));
      if (j == 0) check("t3 first lat", 32'(n), 32'd1);
      else check("t3 irq to launch", 32'(n), 32'd2);
      wait_irq("t3", 20, n);
      check("t3 launch to irq", 32'(n), 32'd3);
      check("t3 irq hart", 32'(mvu_irq), 32'(8'd1 << order[j]));
    end

    // round robin after hart 5: 6 before 0
    cfg(5, 29'd3, 6'd5, 6'd5, 6'd5, 15'h055, 15'h055);
    cfg(0, 29'd1, 6'd0, 6'd0, 6'd0, 15'h000, 15'h000);
    cfg(6, 29'd1, 6'd6, 6'd6, 6'd6, 15'h066, 15'h066);
    mvu_start[5] = 1'b1;
    step();
    mvu_start[5] = 1'b0;
    wait_start("t4 h5", n);
    check("t4 h5 hart", 32'(eng_hart), 32'd5);
    step();
    mvu_start = 8'h41;
    step();
    check("t4 pending", 32'(pending), 32'h41);
    mvu_start = '0;
    wait_irq("t4 h5", 20, n);
    check("t4 h5 irq", 32'(mvu_irq), 32'h20);
    wait_start("t4 a", n);
    check("t4 first", 32'(eng_hart), 32'd6);
    wait_irq("t4 a", 20, n);
    check("t4 a irq", 32'(mvu_irq), 32'h40);
    wait_start("t4 b", n);
    check("t4 second", 32'(eng_hart), 32'd0);
    wait_irq("t4 b", 20, n);
    check("t4 b irq", 32'(mvu_irq), 32'h01);

    // hart 3 restarts while pending, active and in DONE
    cfg(1, 29'd10, 6'd1, 6'd1, 6'd1, 15'h010, 15'h010);
    mvu_start[1] = 1'b1;
    step();
    mvu_start[1] = 1'b0;
    wait_start("t5 h1", n);
    cfg(3, 29'd4, 6'd7, 6'd1, 6'd1, 15'h0AA, 15'h011);
    mvu_start[3] = 1'b1;
    step();
    check("t5 pend", 32'(pending), 32'h08);
    check("t5 no drop", 32'(drop_err), 32'd0);
    mvu_start[3] = 1'b0;
    step();
    cfg(3, 29'd9, 6'd1, 6'd2, 6'd3, 15'h155, 15'h022);
    mvu_start[3] = 1'b1;
    step();
    check("t5 drop pend", 32'(drop_err), 32'h08);
    check("t5 still pend", 32'(pending), 32'h08);
    mvu_start[3] = 1'b0;
    step();
    check("t5 drop once", 32'(drop_err), 32'd0);
    wait_irq("t5 h1", 40, n);
    check("t5 h1 irq", 32'(mvu_irq), 32'h02);
    wait_start("t5 h3", n);
    check("t5 hart", 32'(eng_hart), 32'd3);
    check("t5 snap cd", 32'(eng_countdown), 32'd4);
    check("t5 snap wp", 32'(eng_wprec), 32'd7);
    check("t5 snap ib", 32'(eng_ibase), 32'h0AA);
    step();
    mvu_start[3] = 1'b1;
    step();
    check("t5 drop act", 32'(drop_err), 32'h08);
    check("t5 act cd", 32'(eng_countdown), 32'd4);
    check("t5 act wp", 32'(eng_wprec), 32'd7);
    check("t5 act hart", 32'(eng_hart), 32'd3);
    check("t5 act nopend", 32'(pending), 32'd0);
    mvu_start[3] = 1'b0;
    step();
    check("t5 drop act once", 32'(drop_err), 32'd0);
    wait_irq("t5 h3", 20, n);
    check("t5 h3 irq", 32'(mvu_irq), 32'h08);
    mvu_start[3] = 1'b1;
    step();
    check("t5 done accept", 32'(pending), 32'h08);
    check("t5 done nodrop", 32'(drop_err), 32'd0);
    mvu_start[3] = 1'b0;
    wait_start("t5 re", n);
    check("t5 re cd", 32'(eng_countdown), 32'd9);
    check("t5 re ib", 32'(eng_ibase), 32'h155);
    wait_irq("t5 re", 30, n);
    check("t5 re irq", 32'(mvu_irq), 32'h08);

    // maximum countdown, aborted by reset
    cfg(5, 29'h1FFF_FFFF, 6'd2, 6'd2, 6'd2, 15'h7FFF, 15'h7FFF);
    mvu_start[5] = 1'b1;
    step();
    mvu_start[5] = 1'b0;
    wait_start("t6 max", n);
    check("t6 max cd", 32'(eng_countdown), 32'h1FFF_FFFF);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    check_zero("t6 rst max");
    rst_n = 1'b1;
    step();

    // reset during RUN with countdown 100
    cfg(4, 29'd100, 6'd9, 6'd9, 6'd9, 15'h044, 15'h044);
    mvu_start[4] = 1'b1;
    step();
    mvu_start[4] = 1'b0;
    wait_start("t6 run", n);
    check("t6 hart", 32'(eng_hart), 32'd4);
    check("t6 cd", 32'(eng_countdown), 32'd100);
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    step();
    check_zero("t6 rst run");
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 130; k++) begin
      step();
      if (mvu_irq != '0 || eng_busy) seen = 1'b1;
    end
    check("t6 no irq", 32'(seen), 32'd0);

    // fresh jobs after reset: hart 0 has top priority over 7
    cfg(0, 29'd1, 6'd0, 6'd0, 6'd0, 15'h000, 15'h000);
    cfg(7, 29'd1, 6'd7, 6'd7, 6'd7, 15'h077, 15'h077);
    mvu_start = 8'h81;
    step();
    check("t7 pending", 32'(pending), 32'h81);
    mvu_start = '0;
    wait_start("t7 a", n);
    check("t7 a lat", 32'(n), 32'd1);
    check("t7 a hart", 32'(eng_hart), 32'd0);
    wait_irq("t7 a", 20, n);
    check("t7 a irq lat", 32'(n), 32'd2);
    check("t7 a irq", 32'(mvu_irq), 32'h01);
    wait_start("t7 b", n);
    check("t7 b hart", 32'(eng_hart), 32'd7);
    wait_irq("t7 b", 20, n);
    check("t7 b irq", 32'(mvu_irq), 32'h80);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
